// File: rtl/pe_axil_pkg.sv
// Shared constants and types for the PE AXI4-Lite memory slave.
// Holds response codes, read FSM states, counter width and a saturating increment.
package pe_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         CNT_W       = 16;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pe_axil_mem_array.sv
// Word memory with one byte-enabled write port and one registered read port.
// Read data appears the cycle after re; a same-cycle write to the read word returns old data; no stalls.
module pe_axil_mem_array #(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [DW-1:0]   wdat,
    input  logic [DW/8-1:0] wbe,
    input  logic            re,
    input  logic [AW-1:0]   ra,
    output logic [DW-1:0]   rdat
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdat_q;

    // Both updates are non-blocking, so a colliding read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wbe[b]) begin
                    mem[wa][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdat_q <= mem[ra];
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/pe_axil_mem_slave.sv
// AXI4-Lite slave over on-chip memory; one read and one write outstanding; define PE_AXIL_SLAVE_ERR_EN for SLVERR on out-of-range.
// Read: rvalid READ_LATENCY+1 cycles after AR; write: bvalid 2 cycles after the later of AW/W; both hold until accepted.
module pe_axil_mem_slave
    import pe_axil_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        READ_LATENCY   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   saxi_araddr,
    input  logic                        saxi_arvalid,
    output logic                        saxi_arready,
    input  logic [2:0]                  saxi_arprot,
    output logic [AXI_DATA_WIDTH-1:0]   saxi_rdata,
    output logic [1:0]                  saxi_rresp,
    output logic                        saxi_rvalid,
    input  logic                        saxi_rready,
    input  logic [AXI_ADDR_WIDTH-1:0]   saxi_awaddr,
    input  logic                        saxi_awvalid,
    output logic                        saxi_awready,
    input  logic [2:0]                  saxi_awprot,
    input  logic [AXI_DATA_WIDTH-1:0]   saxi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] saxi_wstrb,
    input  logic                        saxi_wvalid,
    output logic                        saxi_wready,
    output logic [1:0]                  saxi_bresp,
    output logic                        saxi_bvalid,
    input  logic                        saxi_bready,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            wr_count
);

    localparam int             IDX_W     = $clog2(MEM_DEPTH);
    localparam int             BE_W      = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]     WAIT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    // Address decode: offset from base, word index from bits above the byte lane.
    logic [AXI_ADDR_WIDTH-1:0] ar_off, aw_off;
    logic [IDX_W-1:0]          ar_idx, aw_idx;
    logic                      ar_err, aw_err;

    assign ar_off = saxi_araddr - BASE_ADDR;
    assign aw_off = saxi_awaddr - BASE_ADDR;
    assign ar_idx = ar_off[IDX_W+1:2];
    assign aw_idx = aw_off[IDX_W+1:2];

`ifdef PE_AXIL_SLAVE_ERR_EN
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(MEM_DEPTH * 4);
    assign ar_err = (saxi_araddr < BASE_ADDR) || ({1'b0, ar_off} >= MEM_BYTES);
    assign aw_err = (saxi_awaddr < BASE_ADDR) || ({1'b0, aw_off} >= MEM_BYTES);
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{saxi_arprot, saxi_awprot, ar_off, aw_off};

    // Read channel state
    rd_state_t          rd_state_q, rd_state_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]   ar_idx_q, ar_idx_d;
    logic               ar_err_q, ar_err_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic               mem_re;
    logic [IDX_W-1:0]   mem_ra;
    logic [AXI_DATA_WIDTH-1:0] mem_rdat;

    // Write channel state
    logic               aw_full_q, aw_full_d;
    logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic               aw_err_q, aw_err_d;
    logic               w_full_q, w_full_d;
    logic [AXI_DATA_WIDTH-1:0] w_dat_q, w_dat_d;
    logic [BE_W-1:0]    w_strb_q, w_strb_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               commit;

    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_state_d = rd_state_q;
        wait_cnt_d = wait_cnt_q;
        ar_idx_d   = ar_idx_q;
        ar_err_d   = ar_err_q;
        mem_re     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (saxi_arvalid) begin
                    ar_idx_d   = ar_idx;
                    ar_err_d   = ar_err;
                    wait_cnt_d = WAIT_INIT;
                    if (READ_LATENCY == 0) begin
                        rd_state_d = R_RESP;
                        mem_re     = 1'b1;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    rd_state_d = R_RESP;
                    mem_re     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            R_RESP: begin
                if (saxi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_RESP);
    end

    // Zero-latency reads sample straight from the incoming address.
    assign mem_ra = (rd_state_q == R_IDLE) ? ar_idx : ar_idx_q;

    assign commit = aw_full_q && w_full_q && !bvalid_q;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_err_d  = aw_err_q;
        w_full_d  = w_full_q;
        w_dat_d   = w_dat_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (saxi_awvalid && saxi_awready) begin
            aw_full_d = 1'b1;
            aw_idx_d  = aw_idx;
            aw_err_d  = aw_err;
        end
        if (saxi_wvalid && saxi_wready) begin
            w_full_d = 1'b1;
            w_dat_d  = saxi_wdata;
            w_strb_d = saxi_wstrb;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_err_q ? RESP_SLVERR : RESP_OKAY;
        end
        if (bvalid_q && saxi_bready) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
    end

    always_comb begin
        rd_cnt_d = (rvalid_q && saxi_rready) ? sat_inc(rd_cnt_q) : rd_cnt_q;
        wr_cnt_d = (bvalid_q && saxi_bready) ? sat_inc(wr_cnt_q) : wr_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            wait_cnt_q <= 3'd0;
            ar_idx_q   <= '0;
            ar_err_q   <= 1'b0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            w_full_q   <= 1'b0;
            w_dat_q    <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wait_cnt_q <= wait_cnt_d;
            ar_idx_q   <= ar_idx_d;
            ar_err_q   <= ar_err_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            aw_err_q   <= aw_err_d;
            w_full_q   <= w_full_d;
            w_dat_q    <= w_dat_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    pe_axil_mem_array #(
        .DEPTH (MEM_DEPTH),
        .DW    (AXI_DATA_WIDTH),
        .AW    (IDX_W)
    ) u_mem (
        .clk  (clk),
        .we   (commit && !aw_err_q),
        .wa   (aw_idx_q),
        .wdat (w_dat_q),
        .wbe  (w_strb_q),
        .re   (mem_re),
        .ra   (mem_ra),
        .rdat (mem_rdat)
    );

    assign saxi_arready = arready_q;
    assign saxi_rvalid  = rvalid_q;
    assign saxi_rdata   = (rvalid_q && !ar_err_q) ? mem_rdat : '0;
    assign saxi_rresp   = (rvalid_q && ar_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign saxi_awready = !aw_full_q && !bvalid_q;
    assign saxi_wready  = !w_full_q && !bvalid_q;
    assign saxi_bvalid  = bvalid_q;
    assign saxi_bresp   = bresp_q;
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_pe_axil_mem_slave.sv
// Directed bench for pe_axil_mem_slave with default parameters (READ_LATENCY=1, MEM_DEPTH=256, BASE_ADDR=0).
module tb_pe_axil_mem_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] saxi_araddr;
    logic        saxi_arvalid;
    logic        saxi_arready;
    logic [2:0]  saxi_arprot;
    logic [31:0] saxi_rdata;
    logic [1:0]  saxi_rresp;
    logic        saxi_rvalid;
    logic        saxi_rready;
    logic [31:0] saxi_awaddr;
    logic        saxi_awvalid;
    logic        saxi_awready;
    logic [2:0]  saxi_awprot;
    logic [31:0] saxi_wdata;
    logic [3:0]  saxi_wstrb;
    logic        saxi_wvalid;
    logic        saxi_wready;
    logic [1:0]  saxi_bresp;
    logic        saxi_bvalid;
    logic        saxi_bready;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    pe_axil_mem_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .saxi_araddr  (saxi_araddr),
        .saxi_arvalid (saxi_arvalid),
        .saxi_arready (saxi_arready),
        .saxi_arprot  (saxi_arprot),
        .saxi_rdata   (saxi_rdata),
        .saxi_rresp   (saxi_rresp),
        .saxi_rvalid  (saxi_rvalid),
        .saxi_rready  (saxi_rready),
        .saxi_awaddr  (saxi_awaddr),
        .saxi_awvalid (saxi_awvalid),
        .saxi_awready (saxi_awready),
        .saxi_awprot  (saxi_awprot),
        .saxi_wdata   (saxi_wdata),
        .saxi_wstrb   (saxi_wstrb),
        .saxi_wvalid  (saxi_wvalid),
        .saxi_wready  (saxi_wready),
        .saxi_bresp   (saxi_bresp),
        .saxi_bvalid  (saxi_bvalid),
        .saxi_bready  (saxi_bready),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        bit b_done  = 0;
        int n = 0;
        resp = 2'bxx;
        saxi_awaddr = a; saxi_awvalid = 1'b1;
        saxi_wdata  = d; saxi_wstrb   = s; saxi_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_hs = saxi_awvalid && saxi_awready;
            w_hs  = saxi_wvalid && saxi_wready;
            step();
            if (aw_hs) begin aw_done = 1; saxi_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; saxi_wvalid  = 1'b0; end
            n++;
        end
        saxi_bready = 1'b1;
        while (!b_done && n < 50) begin
            @(negedge clk);
            if (saxi_bvalid) begin b_done = 1; resp = saxi_bresp; end
            step();
            n++;
        end
        saxi_bready = 1'b0; saxi_awvalid = 1'b0; saxi_wvalid = 1'b0;
        checks++;
        if (!b_done) begin
            errors++;
            $display("FAIL write_timeout addr=%h: B response not seen, required within 50 cycles", a);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hs = 0;
        int n = 0;
        d = 'x; resp = 2'bxx;
        saxi_araddr = a; saxi_arvalid = 1'b1; saxi_rready = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = saxi_arready;
            step();
            n++;
        end
        saxi_arvalid = 1'b0;
        hs = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            if (saxi_rvalid) begin hs = 1; d = saxi_rdata; resp = saxi_rresp; end
            step();
            n++;
        end
        saxi_rready = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL read_timeout addr=%h: R response not seen, required within 50 cycles", a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({saxi_arready, saxi_awready, saxi_wready, saxi_rvalid, saxi_bvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_handshake: got %b, required 11100",
                     {saxi_arready, saxi_awready, saxi_wready, saxi_rvalid, saxi_bvalid});
        end
        checks++;
        if ({saxi_rdata, saxi_rresp, saxi_bresp} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b, required all zero",
                     saxi_rdata, saxi_rresp, saxi_bresp);
        end
        checks++;
        if ({rd_count, wr_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts: rd=%0d wr=%0d, required 0/0", rd_count, wr_count);
        end
        step();
    endtask

    task automatic test_preload();
        logic [1:0] br;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, br);
        checks++;
        if (br !== 2'b00) begin errors++; $display("FAIL preload_bresp: got %b, required 00", br); end
        saxi_araddr = 32'h10; saxi_arvalid = 1'b1; saxi_rready = 1'b1;
        @(negedge clk);
        checks++;
        if (saxi_arready !== 1'b1) begin errors++; $display("FAIL preload_arready: got %b, required 1", saxi_arready); end
        step();
        saxi_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({saxi_rvalid, saxi_arready} !== 2'b00) begin
            errors++;
            $display("FAIL preload_t1: rvalid/arready=%b, required 00", {saxi_rvalid, saxi_arready});
        end
        step();
        @(negedge clk);
        checks++;
        if (saxi_rvalid !== 1'b1 || saxi_rdata !== 32'hDEADBEEF || saxi_rresp !== 2'b00) begin
            errors++;
            $display("FAIL preload_t2: rvalid=%b rdata=%h rresp=%b, required 1 deadbeef 00",
                     saxi_rvalid, saxi_rdata, saxi_rresp);
        end
        step();
        saxi_rready = 1'b0;
        @(negedge clk);
        checks++;
        if (saxi_rvalid !== 1'b0 || rd_count !== 16'd1 || wr_count !== 16'd1) begin
            errors++;
            $display("FAIL preload_counts: rvalid=%b rd=%0d wr=%0d, required 0 1 1",
                     saxi_rvalid, rd_count, wr_count);
        end
        step();
    endtask

    task automatic test_strobes();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        axi_write(32'h20, 32'h11223344, 4'hF, br);
        axi_write(32'h20, 32'hAABBCCDD, 4'b0101, br);
        axi_read(32'h20, rd, rr);
        checks++;
        if (rd !== 32'h11BB33DD || rr !== 2'b00) begin
            errors++;
            $display("FAIL strobe_merge: rdata=%h rresp=%b, required 11bb33dd 00", rd, rr);
        end
        axi_write(32'h20, 32'hFFFFFFFF, 4'h0, br);
        checks++;
        if (br !== 2'b00) begin errors++; $display("FAIL strobe_zero_bresp: got %b, required 00", br); end
        axi_read(32'h22, rd, rr);
        checks++;
        if (rd !== 32'h11BB33DD || rr !== 2'b00) begin
            errors++;
            $display("FAIL strobe_zero_data: rdata=%h rresp=%b, required 11bb33dd 00", rd, rr);
        end
    endtask

    task automatic test_skew();
        logic [1:0]  rr;
        logic [31:0] rd;
        saxi_wdata = 32'h55667788; saxi_wstrb = 4'hF; saxi_wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (saxi_wready !== 1'b1) begin errors++; $display("FAIL skew_wready0: got %b, required 1", saxi_wready); end
        step();
        saxi_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({saxi_awready, saxi_wready} !== 2'b10) begin
            errors++;
            $display("FAIL skew_wslot: awready/wready=%b, required 10", {saxi_awready, saxi_wready});
        end
        step();
        step();
        saxi_awaddr = 32'h30; saxi_awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (saxi_awready !== 1'b1) begin errors++; $display("FAIL skew_awready: got %b, required 1", saxi_awready); end
        step();
        saxi_awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (saxi_bvalid !== 1'b0) begin errors++; $display("FAIL skew_bvalid_early: got %b, required 0", saxi_bvalid); end
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({saxi_bvalid, saxi_awready, saxi_wready} !== 3'b100 || saxi_bresp !== 2'b00) begin
                errors++;
                $display("FAIL skew_bhold[%0d]: bvalid/awready/wready=%b bresp=%b, required 100 00",
                         i, {saxi_bvalid, saxi_awready, saxi_wready}, saxi_bresp);
            end
            step();
        end
        saxi_bready = 1'b1;
        step();
        saxi_bready = 1'b0;
        @(negedge clk);
        checks++;
        if ({saxi_bvalid, saxi_awready, saxi_wready} !== 3'b011) begin
            errors++;
            $display("FAIL skew_release: bvalid/awready/wready=%b, required 011",
                     {saxi_bvalid, saxi_awready, saxi_wready});
        end
        step();
        axi_read(32'h30, rd, rr);
        checks++;
        if (rd !== 32'h55667788) begin errors++; $display("FAIL skew_data: got %h, required 55667788", rd); end
    endtask

    task automatic test_read_backpressure();
        saxi_araddr = 32'h10; saxi_arvalid = 1'b1; saxi_rready = 1'b0;
        step();
        saxi_arvalid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({saxi_rvalid, saxi_arready} !== 2'b10 || saxi_rdata !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL rbp_hold[%0d]: rvalid/arready=%b rdata=%h, required 10 deadbeef",
                         i, {saxi_rvalid, saxi_arready}, saxi_rdata);
            end
            step();
        end
        saxi_rready = 1'b1;
        saxi_araddr = 32'h30; saxi_arvalid = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({saxi_rvalid, saxi_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rbp_next_ar: rvalid/arready=%b, required 01", {saxi_rvalid, saxi_arready});
        end
        step();
        saxi_arvalid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (saxi_rvalid !== 1'b1 || saxi_rdata !== 32'h55667788) begin
            errors++;
            $display("FAIL rbp_second: rvalid=%b rdata=%h, required 1 55667788", saxi_rvalid, saxi_rdata);
        end
        step();
        saxi_rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        axi_write(32'h0, 32'h01020304, 4'hF, br);
        axi_write(32'h400, 32'hCAFEF00D, 4'hF, br);
`ifdef PE_AXIL_SLAVE_ERR_EN
        checks++;
        if (br !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b, required 10", br); end
        axi_read(32'h400, rd, rr);
        checks++;
        if (rd !== 32'h0 || rr !== 2'b10) begin
            errors++;
            $display("FAIL oor_read: rdata=%h rresp=%b, required 00000000 10", rd, rr);
        end
        axi_read(32'h0, rd, rr);
        checks++;
        if (rd !== 32'h01020304 || rr !== 2'b00) begin
            errors++;
            $display("FAIL oor_word0: rdata=%h rresp=%b, required 01020304 00", rd, rr);
        end
`else
        checks++;
        if (br !== 2'b00) begin errors++; $display("FAIL oor_bresp: got %b, required 00", br); end
        axi_read(32'h0, rd, rr);
        checks++;
        if (rd !== 32'hCAFEF00D || rr !== 2'b00) begin
            errors++;
            $display("FAIL oor_alias_word0: rdata=%h rresp=%b, required cafef00d 00", rd, rr);
        end
        axi_read(32'h400, rd, rr);
        checks++;
        if (rd !== 32'hCAFEF00D || rr !== 2'b00) begin
            errors++;
            $display("FAIL oor_alias_read: rdata=%h rresp=%b, required cafef00d 00", rd, rr);
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        logic [1:0]  rr;
        logic [31:0] rd;
        saxi_araddr = 32'h20; saxi_arvalid = 1'b1; saxi_rready = 1'b1;
        step();
        saxi_arvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({saxi_rvalid, saxi_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_async: rvalid/arready=%b, required 01", {saxi_rvalid, saxi_arready});
        end
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({saxi_rvalid, saxi_arready, saxi_awready, saxi_wready} !== 4'b0111 ||
            rd_count !== 16'd0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_release: rv/ar/aw/w=%b rd=%0d wr=%0d, required 0111 0 0",
                     {saxi_rvalid, saxi_arready, saxi_awready, saxi_wready}, rd_count, wr_count);
        end
        step();
        axi_read(32'h20, rd, rr);
        checks++;
        if (rd !== 32'h11BB33DD || rr !== 2'b00) begin
            errors++;
            $display("FAIL rst_mem_kept: rdata=%h rresp=%b, required 11bb33dd 00", rd, rr);
        end
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd1 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_counts_after: rd=%0d wr=%0d, required 1 0", rd_count, wr_count);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        saxi_araddr = '0; saxi_arvalid = 1'b0; saxi_arprot = 3'b0; saxi_rready = 1'b0;
        saxi_awaddr = '0; saxi_awvalid = 1'b0; saxi_awprot = 3'b0;
        saxi_wdata = '0; saxi_wstrb = '0; saxi_wvalid = 1'b0; saxi_bready = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_preload();
        test_strobes();
        test_skew();
        test_read_backpressure();
        test_out_of_range();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
